sar_result_buffer: RTL and testbench

Downstream capture stage for `sar_control`; it consumes the `load_reg`/`reg_wdata` result strobe and presents finished conversion codes to the digital back end. It optionally averages 2^AVG_LOG2 consecutive conversions (oversampling). It queues results in a small synchronous FIFO with a valid/ready output handshake. It flags overflow when the consumer stalls and a result has nowhere to go.

---
 rtl/sar_pkg.sv | 19 +
 rtl/sar_sync_fifo.sv | 59 +++++
 rtl/sar_result_buffer.sv | 100 ++++++++++
 tb/tb_sar_result_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared defaults and width helpers for the SAR result capture path.
package sar_pkg;

  localparam int unsigned SAR_WIDTH    = 3;
  localparam int unsigned SAR_DEPTH    = 4;
  localparam int unsigned SAR_AVG_LOG2 = 2;

  function automatic int unsigned acc_width(input int unsigned width, input int unsigned avg_log2);
    return width + avg_log2;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned SAR_ACC_W   = acc_width(SAR_WIDTH, SAR_AVG_LOG2);
  localparam int unsigned SAR_LEVEL_W = level_width(SAR_DEPTH);

endpackage

// File: rtl/sar_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head data reads as zero when empty.
module sar_sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_en  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_en = push & (~full | pop_en);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sar_result_buffer.sv
// Capture stage behind sar_control: optional oversampling average, result FIFO, sticky status.
// Averaging is compiled in when SAR_RESULT_AVG_EN is defined.
module sar_result_buffer
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH    = SAR_WIDTH,
  parameter int unsigned DEPTH    = SAR_DEPTH,
  parameter int unsigned AVG_LOG2 = SAR_AVG_LOG2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_reg,
  input  logic [WIDTH-1:0]           reg_wdata,
  input  logic                       eoc_n,
  input  logic                       clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       conv_seen
);

  if (AVG_LOG2 < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("sar_result_buffer: illegal DEPTH/AVG_LOG2");
  end

  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic             drop;

`ifdef SAR_RESULT_AVG_EN
  localparam int unsigned ACC_W = acc_width(WIDTH, AVG_LOG2);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] phase;

  assign acc_sum    = acc + ACC_W'(reg_wdata);
  assign word_valid = load_reg & ~clr & (&phase);
  assign word_data  = WIDTH'(acc_sum >> AVG_LOG2);

  // The accumulator restarts on the final sample even if the FIFO drops the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (clr) begin
      acc   <= '0;
      phase <= '0;
    end else if (load_reg) begin
      if (&phase) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= acc_sum;
        phase <= phase + 1'b1;
      end
    end
  end
`else
  assign word_valid = load_reg & ~clr;
  assign word_data  = reg_wdata;
`endif

  sar_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (word_valid),
    .push_data (word_data),
    .pop       (out_ready),
    .rd_data   (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

  assign out_valid = ~fifo_empty;
  assign drop      = word_valid & fifo_full & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      conv_seen <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      conv_seen <= 1'b0;
    end else begin
      if (drop)   overflow  <= 1'b1;
      if (!eoc_n) conv_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sar_result_buffer.sv
// Scoreboard bench for sar_result_buffer: directed pushes queue expected words, a monitor checks pops.
module tb_sar_result_buffer;

  localparam int W  = 3;
  localparam int D  = 4;
  localparam int A  = 2;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_reg = 1'b0;
  logic [W-1:0]  reg_wdata = '0;
  logic          eoc_n = 1'b1;
  logic          clr = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;
  logic          overflow;
  logic          conv_seen;

  int n_tests = 0;
  int n_fail  = 0;
  int max_level = 0;
  logic [W-1:0] exp_q [$];

  sar_result_buffer #(.WIDTH(W), .DEPTH(D), .AVG_LOG2(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_reg  (load_reg),
    .reg_wdata (reg_wdata),
    .eoc_n     (eoc_n),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .conv_seen (conv_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: sees the handshake state that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0d, expected no word", out_data);
        end else begin
          check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end else if (!out_valid) begin
        check("empty_data_zero", 32'(out_data), 0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] code);
    load_reg  = 1'b1;
    reg_wdata = code;
    cycle();
    load_reg  = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cycle();
    end
    out_ready = 1'b0;
    check({name, "_queue_left"}, 32'(exp_q.size()), 0);
    check({name, "_valid"}, 32'(out_valid), 0);
    check({name, "_level"}, 32'(level), 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_conv_seen", 32'(conv_seen), 0);
    cycle();
    rst_n = 1'b1;
    cycle();

`ifndef SAR_RESULT_AVG_EN
    // Streaming with a ready consumer: occupancy stays at one.
    max_level = 0;
    out_ready = 1'b1;
    exp_q.push_back(3'd5); load(3'd5);
    exp_q.push_back(3'd2); load(3'd2);
    exp_q.push_back(3'd7); load(3'd7);
    repeat (3) cycle();
    check("t1_max_level", 32'(max_level), 1);
    drain("t1");

    // Stalled consumer: fifth word is dropped.
    out_ready = 1'b0;
    exp_q.push_back(3'd1); load(3'd1);
    check("t2_latency_valid", 32'(out_valid), 1);
    check("t2_latency_data", 32'(out_data), 1);
    exp_q.push_back(3'd2); load(3'd2);
    exp_q.push_back(3'd3); load(3'd3);
    exp_q.push_back(3'd4); load(3'd4);
    check("t2_full_level", 32'(level), 4);
    check("t2_full_no_ovf", 32'(overflow), 0);
    load(3'd5);
    check("t2_drop_level", 32'(level), 4);
    check("t2_drop_ovf", 32'(overflow), 1);
    check("t2_head_kept", 32'(out_data), 1);
    drain("t2");
    check("t2_ovf_sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous push and pop.
    do_clr();
    check("t3_clr_ovf", 32'(overflow), 0);
    exp_q.push_back(3'd3); load(3'd3);
    exp_q.push_back(3'd1); load(3'd1);
    exp_q.push_back(3'd4); load(3'd4);
    exp_q.push_back(3'd2); load(3'd2);
    out_ready = 1'b1;
    exp_q.push_back(3'd6); load(3'd6);
    out_ready = 1'b0;
    check("t3_level", 32'(level), 4);
    check("t3_ovf", 32'(overflow), 0);
    check("t3_head", 32'(out_data), 1);
    drain("t3");

    // Flush with pending data, overflow and a coincident load/eoc.
    exp_q.push_back(3'd1); load(3'd1);
    exp_q.push_back(3'd2); load(3'd2);
    exp_q.push_back(3'd3); load(3'd3);
    exp_q.push_back(3'd4); load(3'd4);
    load(3'd5);
    eoc_n = 1'b0;
    cycle();
    eoc_n = 1'b1;
    check("t4_pre_ovf", 32'(overflow), 1);
    check("t4_pre_conv", 32'(conv_seen), 1);
    clr = 1'b1; eoc_n = 1'b0; load_reg = 1'b1; reg_wdata = 3'd7;
    cycle();
    clr = 1'b0; eoc_n = 1'b1; load_reg = 1'b0;
    exp_q.delete();
    check("t4_level", 32'(level), 0);
    check("t4_valid", 32'(out_valid), 0);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_conv", 32'(conv_seen), 0);
    exp_q.push_back(3'd4); load(3'd4);
    check("t4_after_level", 32'(level), 1);
    drain("t4");
`else
    // Averaging: four samples per word, truncating.
    out_ready = 1'b1;
    load(3'd1); load(3'd2); load(3'd3);
    check("a1_no_word", 32'(out_valid), 0);
    exp_q.push_back(3'd3); load(3'd6);
    check("a1_valid", 32'(out_valid), 1);
    check("a1_data", 32'(out_data), 3);
    load(3'd7); load(3'd7); load(3'd7);
    exp_q.push_back(3'd6); load(3'd6);
    drain("a2");

    // Flush mid-average with two queued words.
    out_ready = 1'b0;
    repeat (2) begin
      load(3'd1); load(3'd1); load(3'd1);
      exp_q.push_back(3'd1); load(3'd1);
    end
    load(3'd7); load(3'd7);
    check("a3_pre_level", 32'(level), 2);
    do_clr();
    check("a3_level", 32'(level), 0);
    check("a3_valid", 32'(out_valid), 0);
    check("a3_ovf", 32'(overflow), 0);
    load(3'd4); load(3'd4); load(3'd4);
    exp_q.push_back(3'd4); load(3'd4);
    check("a3_data", 32'(out_data), 4);
    drain("a3");
`endif

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    eoc_n = 1'b0;
`ifndef SAR_RESULT_AVG_EN
    exp_q.push_back(3'd3); load(3'd3);
    exp_q.push_back(3'd6); load(3'd6);
    check("r_pre_level", 32'(level), 2);
`else
    load(3'd3); load(3'd6);
`endif
    check("r_pre_conv", 32'(conv_seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_valid", 32'(out_valid), 0);
    check("r_data", 32'(out_data), 0);
    check("r_level", 32'(level), 0);
    check("r_ovf", 32'(overflow), 0);
    check("r_conv", 32'(conv_seen), 0);
    exp_q.delete();
    eoc_n = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("r_post_conv_idle", 32'(conv_seen), 0);
    eoc_n = 1'b0;
    cycle();
    eoc_n = 1'b1;
    check("r_post_conv_seen", 32'(conv_seen), 1);
    check("r_post_level", 32'(level), 0);

    repeat (2) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
